and_result_tx: RTL
==================

# and_result_tx

Serial transmit end for the 8-bit AND datapath. On a start strobe it captures two operands, computes their bitwise AND and shifts the result out on a single idle-high pin as an asynchronous-serial frame. It sits between the operand pins of the top-level wrapper and one output pin, giving off-chip observers the AND result over one wire.

## Interface
Parameters:
- `CLKS_PER_BIT`, 4, clock cycles each frame bit is held. Legal range 1..255.

Ports:
- `clk` input 1: the single clock. All state changes on the rising edge.
- `reset` input 1: synchronous, active-high reset, sampled on the rising edge of `clk`.
- `a` input 8: operand A, sampled only at frame accept.
- `b` input 8: operand B, sampled only at frame accept.
- `start` input 1: request to transmit `a & b`. Level-sampled.
- `busy` output 1: high while a frame is in flight.
- `done` output 1: one-cycle pulse after the stop bit completes.
- `tx` output 1: serial line. Idles high.
- `y` output 8: latched AND result of the last accepted frame.

## Operation
- FSM states: IDLE, START, DATA, (PARITY), STOP.
- IDLE:
  - `tx`=1 and `busy`=0.
  - If `start`=1, then on that edge: `y` <= `a & b`; shift register <= `a & b`; bit counter <= 0; baud counter <= 0; state <= START.
- START: `tx`=0 for `CLKS_PER_BIT` cycles, then go to DATA.
- DATA:
  - `tx` = shift register bit 0, so bits go out LSB first.
  - Each bit lasts `CLKS_PER_BIT` cycles, then the register shifts right by 1 and the bit counter increments.
  - After bit 7, go to PARITY if `AND_TX_PARITY_EN` is defined, otherwise go to STOP.
- PARITY: `tx` = XOR of `y` (even parity) for `CLKS_PER_BIT` cycles, then go to STOP.
- STOP: `tx`=1 for `CLKS_PER_BIT` cycles, then go to IDLE with `done`=1 for exactly that first IDLE cycle.
- Counters:
  - Baud counter is $clog2(CLKS_PER_BIT)+1 bits. It resets to 0 at every bit boundary.
  - Bit counter is 3 bits, 0..7. Its wrap from 7 to 0 coincides with leaving DATA.
- `start` while `busy`=1 is ignored. Nothing is queued, and `a`, `b` and `y` are not re-sampled.
- `start` held high continuously produces back-to-back frames: a new frame is accepted on the IDLE cycle in which `done`=1.
- `y` holds its value until the next accept.

## Timing
- Reset values: `tx`=1, `busy`=0, `done`=0, `y`=8'h00, state IDLE, all counters 0.
- Accept edge to first start-bit cycle: 1 cycle. `busy` and `tx`=0 appear in the same cycle as each other.
- Frame length, start through stop:
  - 10×`CLKS_PER_BIT` cycles without parity.
  - 11×`CLKS_PER_BIT` cycles with parity.
- `busy` is high for exactly the frame length.
- `done` rises the cycle after the last stop-bit cycle, at the same moment `busy` falls.
- `CLKS_PER_BIT`=1: each bit occupies exactly one cycle. There is no off-by-one.
- Reset mid-frame: on the next edge `tx`=1, `busy`=0, `done`=0, `y`=0. The frame is aborted with no stop bit and no `done`.
- Reset and `start` asserted together: reset wins, and no frame is accepted.

## Configuration
- `AND_TX_PARITY_EN` defined:
  - An even-parity bit equal to ^`y` is sent between data bit 7 and the stop bit.
  - Frame is 11 bits.
- Not defined:
  - No PARITY state is built.
  - Frame is 10 bits: start, 8 data, stop.

## Test plan
- Reset check: assert `reset` for 2 cycles, then release. Required: `tx`=1, `busy`=0, `done`=0, `y`=00.
- Basic frame, no parity, `CLKS_PER_BIT`=4, `a`=F0, `b`=3C, pulse `start`:
  - `y`=30.
  - `tx` bit sequence 0,0,0,0,0,1,1,0,0,1, each bit held 4 cycles.
  - `busy` high 40 cycles, then a 1-cycle `done`.
- Parity build, `a`=FF, `b`=07:
  - `y`=07.
  - Data bits 1,1,1,0,0,0,0,0, then parity 1, then stop 1.
  - `busy` high 44 cycles.
- Ignore while busy: `start` with `a`=AA, `b`=FF, then mid-frame `start` with `a`=00, `b`=00. Required: `y` stays AA, a single frame is sent, and one `done` pulse.
- Back-to-back: hold `start`=1 with `a`=81, `b`=FF. Required: the second frame's start bit begins the cycle after `done`, with no extra idle cycles.
- Reset mid-frame: assert `reset` during data bit 3. Required:
  - Next cycle `tx`=1, `busy`=0, `y`=00, and no `done`.
  - A subsequent `start` sends a correct frame.

Source files
------------

// File: rtl/and_result_tx.sv
// and_result_tx: serial transmit end for the 8-bit AND datapath.
// On an accepted start it latches a & b, then sends one idle-high frame:
// a start bit, 8 data bits LSB first, an optional even-parity bit, and a stop bit.
// Optional feature macro: AND_TX_PARITY_EN (adds the even-parity bit, 11-bit frame).
module and_result_tx #(
    parameter int unsigned CLKS_PER_BIT = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] a,
    input  logic [7:0] b,
    input  logic       start,
    output logic       busy,
    output logic       done,
    output logic       tx,
    output logic [7:0] y
);

    localparam int unsigned          BAUD_W    = $clog2(CLKS_PER_BIT) + 1;
    localparam logic [BAUD_W-1:0]    BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
`ifdef AND_TX_PARITY_EN
        PARITY,
`endif
        STOP
    } state_t;

    state_t            state;
    logic [BAUD_W-1:0] baud_cnt;
    logic [2:0]        bit_cnt;
    logic [7:0]        shreg;
    logic              bit_end;

    // Last cycle of the current frame bit.
    always_comb begin
        bit_end = (baud_cnt == BAUD_LAST);
    end

    // Frame sequencer; tx, busy and done are registered so they change together
    // with the state they belong to.
    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= IDLE;
            baud_cnt <= '0;
            bit_cnt  <= '0;
            shreg    <= '0;
            y        <= '0;
            tx       <= 1'b1;
            busy     <= 1'b0;
            done     <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        y        <= a & b;
                        shreg    <= a & b;
                        bit_cnt  <= '0;
                        baud_cnt <= '0;
                        state    <= START;
                        tx       <= 1'b0;
                        busy     <= 1'b1;
                    end
                end
                START: begin
                    if (bit_end) begin
                        baud_cnt <= '0;
                        state    <= DATA;
                        tx       <= shreg[0];
                    end else begin
                        baud_cnt <= baud_cnt + BAUD_W'(1);
                    end
                end
                DATA: begin
                    if (bit_end) begin
                        // tx is registered, so the next bit is taken from shreg[1]
                        // in the same edge that shifts the register.
                        baud_cnt <= '0;
                        shreg    <= shreg >> 1;
                        bit_cnt  <= bit_cnt + 3'd1;
                        if (bit_cnt == 3'd7) begin
`ifdef AND_TX_PARITY_EN
                            state <= PARITY;
                            tx    <= ^y;
`else
                            state <= STOP;
                            tx    <= 1'b1;
`endif
                        end else begin
                            tx <= shreg[1];
                        end
                    end else begin
                        baud_cnt <= baud_cnt + BAUD_W'(1);
                    end
                end
`ifdef AND_TX_PARITY_EN
                PARITY: begin
                    if (bit_end) begin
                        baud_cnt <= '0;
                        state    <= STOP;
                        tx       <= 1'b1;
                    end else begin
                        baud_cnt <= baud_cnt + BAUD_W'(1);
                    end
                end
`endif
                STOP: begin
                    if (bit_end) begin
                        baud_cnt <= '0;
                        state    <= IDLE;
                        tx       <= 1'b1;
                        busy     <= 1'b0;
                        done     <= 1'b1;
                    end else begin
                        baud_cnt <= baud_cnt + BAUD_W'(1);
                    end
                end
                default: begin
                    state <= IDLE;
                    tx    <= 1'b1;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule
